cam_pattern_tx: RTL

Camera-side pixel-bus transmitter: generates the vsync/href/8-bit data stream of a parallel camera sensor (RGB565, two bytes per pixel, high byte first) from an internal test-pattern engine. Drives the capture path on the FPGA during simulation and bring-up without a physical sensor, and serves as a loop-back source for the frame buffer. All outputs are registered in the `p_clock` domain.

---
 rtl/cam_pattern_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cam_pattern_tx.sv
// rtl/cam_pattern_tx.sv - parallel camera sensor emulator (vsync/href/8-bit RGB565) with test patterns
module cam_pattern_tx #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 120,
  parameter int H_BLANK    = 32,
  parameter int VSYNC_CLKS = 64,
  parameter int V_BP_CLKS  = 32,
  parameter int V_FP_CLKS  = 32
) (
  input  logic        p_clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  p_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int CW    = 16;
  localparam int BAR_W = H_ACTIVE / 8;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_LINE, S_HBLANK, S_VFP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   y_q, y_d;
  logic [CW-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [7:0]      bcnt_q, bcnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [15:0]     fc_d;
  logic [15:0]     pix;
  logic [7:0]      data_d;
  logic            vsync_d, href_d, busy_d, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    y_d       = y_q;
    bar_idx_d = bar_idx_q;
    bar_cnt_d = bar_cnt_q;
    bcnt_d    = bcnt_q + {7'd0, href};
    sel_d     = sel_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          sel_d   = pattern_sel;
        end
      end
      S_VSYNC: if (cnt_q == CW'(VSYNC_CLKS - 1)) begin
        state_d = S_VBP;
        cnt_d   = '0;
      end
      S_VBP: begin
        bcnt_d = '0;
        y_d    = '0;
        if (cnt_q == CW'(V_BP_CLKS - 1)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: if (cnt_q == CW'(2 * H_ACTIVE - 1)) begin
        state_d = S_HBLANK;
        cnt_d   = '0;
      end
      S_HBLANK: if (cnt_q == CW'(H_BLANK - 1)) begin
        cnt_d = '0;
        if (y_q == CW'(V_ACTIVE - 1)) begin
          state_d = S_VFP;
        end else begin
          state_d = S_LINE;
          y_d     = y_q + CW'(1);
        end
      end
      S_VFP: if (cnt_q == CW'(V_FP_CLKS - 1)) begin
        cnt_d = '0;
        if (enable) begin
          state_d = S_VSYNC;
          sel_d   = pattern_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bar position advances after each odd byte; restarts at every line entry.
    if (state_d != S_LINE || state_q != S_LINE) begin
      bar_idx_d = '0;
      bar_cnt_d = '0;
    end else if (cnt_q[0]) begin
      if (bar_cnt_q == CW'(BAR_W - 1)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + CW'(1);
      end
    end

    // Pixel of the next cycle: x = cnt_d >> 1, byte phase = cnt_d[0].
    pix = 16'h0000;
    case (sel_q)
      2'd0: begin
        case (bar_idx_d)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = {cnt_d[5:1], y_d[5:0], frame_count[4:0]};
      2'd2:    pix = (cnt_d[4] ^ y_d[3]) ? 16'hFFFF : 16'h0000;
      default: pix = {bcnt_d, bcnt_d};
    endcase

    href_d  = (state_d == S_LINE);
    vsync_d = (state_d == S_IDLE) || (state_d == S_VSYNC);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_VFP) && (cnt_d == CW'(V_FP_CLKS - 1));
    fc_d    = frame_count + {15'd0, done_d};
    data_d  = href_d ? (cnt_d[0] ? pix[7:0] : pix[15:8]) : 8'd0;
  end

  always_ff @(posedge p_clock or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      y_q         <= '0;
      bar_cnt_q   <= '0;
      bar_idx_q   <= '0;
      bcnt_q      <= '0;
      sel_q       <= '0;
      vsync       <= 1'b1;
      href        <= 1'b0;
      p_data      <= 8'd0;
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_idx_q   <= bar_idx_d;
      bcnt_q      <= bcnt_d;
      sel_q       <= sel_d;
      vsync       <= vsync_d;
      href        <= href_d;
      p_data      <= data_d;
      frame_done  <= done_d;
      frame_count <= fc_d;
      busy        <= busy_d;
    end
  end

endmodule
